// File: rtl/buffer_loader_pkg.sv
// Shared definitions for the stream-to-row packer feeding the register-array buffer.
// Holds the FSM encoding and the word/row geometry helpers.
package buffer_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic int words_per_vec(input int vec_width, input int in_width);
    return vec_width / in_width;
  endfunction

  function automatic bit widths_divisible(input int vec_width, input int in_width);
    return (in_width > 0) && ((vec_width % in_width) == 0);
  endfunction

endpackage

// File: rtl/buffer_loader.sv
// Packs IN_WIDTH-bit stream words LSB-first into VEC_WIDTH-bit rows and writes
// each completed row to the buffer at incrementing addresses from 0.
//
// state | meaning
// IDLE  | waiting for i_start with a non-zero row count
// LOAD  | accepting words, writing each finished row
// DRAIN | final row write in flight, o_done follows
module buffer_loader
  import buffer_loader_pkg::*;
#(
  parameter int IN_WIDTH   = 32,
  parameter int VEC_WIDTH  = 384,
  parameter int ARR_DEPTH  = 16,
  parameter int ADDR_WIDTH = $clog2(ARR_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_num_rows,
  input  logic                  i_abort,
  input  logic                  i_valid,
  input  logic [IN_WIDTH-1:0]   i_data,
  output logic                  o_ready,
  output logic                  o_we,
  output logic [ADDR_WIDTH-1:0] o_addr_wr,
  output logic [VEC_WIDTH-1:0]  o_data_wr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int WORDS_PER_VEC = words_per_vec(VEC_WIDTH, IN_WIDTH);
  localparam int WCW           = (WORDS_PER_VEC > 1) ? $clog2(WORDS_PER_VEC) : 1;

  localparam logic [WCW-1:0]        LAST_WORD = WCW'(WORDS_PER_VEC - 1);
  localparam logic [WCW-1:0]        WORD_ONE  = WCW'(1);
  localparam logic [ADDR_WIDTH-1:0] ROW_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(ARR_DEPTH);

  if (!widths_divisible(VEC_WIDTH, IN_WIDTH)) begin : g_bad_width
    $error("buffer_loader: VEC_WIDTH must be an integer multiple of IN_WIDTH");
  end

  state_e                                   state;
  logic [WCW-1:0]                           word_cnt;
  logic [ADDR_WIDTH-1:0]                    row_cnt;
  logic [ADDR_WIDTH:0]                      num_rows_q;
  logic [WORDS_PER_VEC-1:0][IN_WIDTH-1:0]   asm_q;
  logic [WORDS_PER_VEC-1:0][IN_WIDTH-1:0]   row_vec;

  logic accept;
  logic row_done;
  logic last_row;

  assign o_ready  = (state == ST_LOAD);
  assign o_busy   = (state != ST_IDLE);
  assign accept   = i_valid && o_ready;
  assign row_done = accept && (word_cnt == LAST_WORD);
  assign last_row = ({1'b0, row_cnt} == (num_rows_q - CNT_ONE));

  // The row written out must already contain the word accepted this cycle.
  always_comb begin
    row_vec                    = asm_q;
    row_vec[WORDS_PER_VEC - 1] = i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      word_cnt   <= '0;
      row_cnt    <= '0;
      num_rows_q <= '0;
      asm_q      <= '0;
      o_we       <= 1'b0;
      o_addr_wr  <= '0;
      o_data_wr  <= '0;
      o_done     <= 1'b0;
    end else if (i_abort && (state != ST_IDLE)) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      row_cnt  <= '0;
      asm_q    <= '0;
      o_we     <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_we   <= 1'b0;
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start && (i_num_rows != '0)) begin
            state      <= ST_LOAD;
            num_rows_q <= (i_num_rows > DEPTH_CNT) ? DEPTH_CNT : i_num_rows;
            word_cnt   <= '0;
            row_cnt    <= '0;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            asm_q[word_cnt] <= i_data;
            if (row_done) begin
              o_we      <= 1'b1;
              o_addr_wr <= row_cnt;
              o_data_wr <= row_vec;
              word_cnt  <= '0;
              // Row counter parks at 0 after the last row so it never passes ARR_DEPTH-1.
              if (last_row) begin
                state   <= ST_DRAIN;
                row_cnt <= '0;
              end else begin
                row_cnt <= row_cnt + ROW_ONE;
              end
            end else begin
              word_cnt <= word_cnt + WORD_ONE;
            end
          end
        end
        ST_DRAIN: begin
          state  <= ST_IDLE;
          o_done <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_buffer_loader.sv
// Self-checking bench for buffer_loader: a transaction-level model (word queue per row,
// row/target counts) predicts the writes and status outputs, compared every cycle.
module tb_buffer_loader;

  localparam int IW  = 32;
  localparam int VW  = 384;
  localparam int D   = 16;
  localparam int AW  = 4;
  localparam int WPV = VW / IW;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [AW:0]   i_num_rows = '0;
  logic          i_abort = 1'b0;
  logic          i_valid = 1'b0;
  logic [IW-1:0] i_data = '0;
  logic          o_ready, o_we, o_busy, o_done;
  logic [AW-1:0] o_addr_wr;
  logic [VW-1:0] o_data_wr;

  buffer_loader #(.IN_WIDTH(IW), .VEC_WIDTH(VW), .ARR_DEPTH(D), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_num_rows(i_num_rows),
    .i_abort(i_abort), .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_we(o_we), .o_addr_wr(o_addr_wr), .o_data_wr(o_data_wr), .o_busy(o_busy),
    .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 loading, 2 final write issued.
  int            m_phase = 0;
  int            m_target = 0;
  int            m_rows = 0;
  logic [IW-1:0] m_words[$];
  logic          m_we = 1'b0;
  logic          m_done = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [VW-1:0] m_data = '0;
  logic [VW-1:0] m_buf[D];

  function automatic logic [VW-1:0] pack_row(input logic [IW-1:0] w[$]);
    logic [VW-1:0] v = '0;
    for (int k = 0; k < WPV; k++) v[k*IW +: IW] = w[k];
    return v;
  endfunction

  always @(negedge i_rst_n) begin
    m_phase = 0; m_rows = 0; m_words.delete();
    m_we = 1'b0; m_done = 1'b0; m_addr = '0; m_data = '0;
  end

  always @(posedge i_clk) begin
    if (i_rst_n) begin
      m_we = 1'b0;
      m_done = 1'b0;
      if (m_phase != 0 && i_abort) begin
        m_phase = 0;
        m_words.delete();
      end else if (m_phase == 0) begin
        if (i_start && i_num_rows != 0) begin
          m_phase = 1;
          m_target = (int'(i_num_rows) > D) ? D : int'(i_num_rows);
          m_rows = 0;
          m_words.delete();
        end
      end else if (m_phase == 1) begin
        if (i_valid) begin
          m_words.push_back(i_data);
          if (m_words.size() == WPV) begin
            m_we = 1'b1;
            m_addr = AW'(m_rows);
            m_data = pack_row(m_words);
            m_buf[m_rows] = m_data;
            m_words.delete();
            m_rows++;
            if (m_rows == m_target) m_phase = 2;
          end
        end
      end else begin
        m_phase = 0;
        m_done = 1'b1;
      end
    end
  end

  // Per-cycle compare plus a log of observed writes/done pulses for directed checks.
  int            cyc = 0;
  logic [AW-1:0] wr_addr[$];
  logic [VW-1:0] wr_data[$];
  int            wr_cyc[$];
  int            done_cnt = 0;
  int            done_cyc = 0;

  always @(negedge i_clk) begin
    cyc++;
    if (i_rst_n) begin
      chk("ready", VW'(o_ready), VW'(m_phase == 1));
      chk("busy",  VW'(o_busy),  VW'(m_phase != 0));
      chk("we",    VW'(o_we),    VW'(m_we));
      chk("done",  VW'(o_done),  VW'(m_done));
      chk("addr",  VW'(o_addr_wr), VW'(m_addr));
      chk("data",  o_data_wr, m_data);
      if (o_we) begin
        wr_addr.push_back(o_addr_wr);
        wr_data.push_back(o_data_wr);
        wr_cyc.push_back(cyc);
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); done_cnt = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge i_clk); #1;
    end
  endtask

  task automatic start_load(input int n);
    i_start = 1'b1; i_num_rows = (AW + 1)'(n);
    tick(1);
    i_start = 1'b0;
  endtask

  // mode 0: continuous valid, 1: toggling, 2: random. rnd selects random data, else base+index.
  task automatic send_words(input int n, input int mode, input bit rnd, input int base);
    int idx = 0;
    int budget = 0;
    bit acc;
    bit tog = 1'b0;
    while (idx < n) begin
      case (mode)
        0:       i_valid = 1'b1;
        1:       begin i_valid = tog; tog = ~tog; end
        default: i_valid = 1'($urandom_range(0, 1));
      endcase
      i_data = rnd ? IW'($urandom) : IW'(base + idx);
      acc = i_valid && o_ready;
      tick(1);
      if (acc) idx++;
      budget++;
      if (budget > 20 * n + 50) begin
        errs++; checks++;
        $display("FAIL send_timeout: accepted %0d expected %0d", idx, n);
        break;
      end
    end
    i_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int b = 0;
    while (o_busy && b < 50) begin tick(1); b++; end
    checks++;
    if (o_busy) begin
      errs++;
      $display("FAIL idle_timeout: busy %0b expected 0", o_busy);
    end
    tick(3);
  endtask

  logic [VW-1:0] lit_row;

  initial begin
    tick(2);
    chk("rst_we",   VW'(o_we), '0);
    chk("rst_done", VW'(o_done), '0);
    chk("rst_busy", VW'(o_busy), '0);
    chk("rst_data", o_data_wr, '0);
    @(negedge i_clk); i_rst_n = 1'b1;
    tick(2);

    // Single row, continuous
    clear_log();
    start_load(1);
    send_words(WPV, 0, 1'b0, 0);
    wait_idle();
    lit_row = {32'hB, 32'hA, 32'h9, 32'h8, 32'h7, 32'h6,
               32'h5, 32'h4, 32'h3, 32'h2, 32'h1, 32'h0};
    chk("single_nwr", VW'(wr_addr.size()), VW'(1));
    if (wr_addr.size() == 1) begin
      chk("single_addr", VW'(wr_addr[0]), '0);
      chk("single_data", wr_data[0], lit_row);
      chk("single_done_lat", VW'(done_cyc - wr_cyc[0]), VW'(1));
    end
    chk("single_model", m_buf[0], lit_row);
    chk("single_ndone", VW'(done_cnt), VW'(1));
    chk("single_ready_after", VW'(o_ready), '0);

    // Full 16 rows, toggling valid, value = index
    clear_log();
    start_load(16);
    send_words(D * WPV, 1, 1'b0, 0);
    wait_idle();
    chk("full_nwr", VW'(wr_addr.size()), VW'(16));
    for (int r = 0; r < 16 && r < wr_addr.size(); r++) begin
      chk("full_addr", VW'(wr_addr[r]), VW'(r));
      chk("full_word0", VW'(wr_data[r][IW-1:0]), VW'(12 * r));
      chk("full_buf", wr_data[r], m_buf[r]);
    end
    chk("full_model15", VW'(m_buf[15][IW-1:0]), VW'(180));
    chk("full_ndone", VW'(done_cnt), VW'(1));
    if (wr_cyc.size() == 16) chk("full_done_after", VW'(done_cyc - wr_cyc[15]), VW'(1));

    // Zero count ignored, then clamp 20 -> 16
    clear_log();
    start_load(0);
    tick(1);
    chk("zero_busy", VW'(o_busy), '0);
    tick(3);
    chk("zero_ndone", VW'(done_cnt), '0);
    start_load(20);
    send_words(D * WPV, 2, 1'b1, 0);
    wait_idle();
    chk("clamp_nwr", VW'(wr_addr.size()), VW'(16));
    chk("clamp_ndone", VW'(done_cnt), VW'(1));

    // Abort on final word of row 2
    clear_log();
    start_load(4);
    send_words(2 * WPV + WPV - 1, 2, 1'b1, 0);
    i_valid = 1'b1; i_data = IW'($urandom); i_abort = 1'b1;
    tick(1);
    i_valid = 1'b0; i_abort = 1'b0;
    chk("abort_busy", VW'(o_busy), '0);
    tick(4);
    chk("abort_nwr", VW'(wr_addr.size()), VW'(2));
    chk("abort_ndone", VW'(done_cnt), '0);
    clear_log();
    start_load(1);
    send_words(WPV, 0, 1'b1, 0);
    wait_idle();
    chk("restart_nwr", VW'(wr_addr.size()), VW'(1));
    if (wr_addr.size() == 1) chk("restart_addr", VW'(wr_addr[0]), '0);

    // Ignored start during LOAD
    clear_log();
    start_load(2);
    send_words(3, 0, 1'b1, 0);
    i_start = 1'b1; i_num_rows = 5'd5;
    tick(1);
    i_start = 1'b0;
    send_words(2 * WPV - 3, 2, 1'b1, 0);
    wait_idle();
    chk("ign_nwr", VW'(wr_addr.size()), VW'(2));
    chk("ign_ndone", VW'(done_cnt), VW'(1));

    // Async reset mid-load
    clear_log();
    start_load(2);
    send_words(5, 0, 1'b1, 0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("mrst_we",    VW'(o_we), '0);
    chk("mrst_ready", VW'(o_ready), '0);
    chk("mrst_busy",  VW'(o_busy), '0);
    chk("mrst_done",  VW'(o_done), '0);
    chk("mrst_addr",  VW'(o_addr_wr), '0);
    chk("mrst_data",  o_data_wr, '0);
    tick(2);
    i_rst_n = 1'b1;
    tick(2);
    chk("mrst_nwr", VW'(wr_addr.size()), '0);
    start_load(1);
    send_words(WPV, 2, 1'b1, 0);
    wait_idle();
    chk("mrst_restart_nwr", VW'(wr_addr.size()), VW'(1));
    if (wr_addr.size() == 1) begin
      chk("mrst_restart_addr", VW'(wr_addr[0]), '0);
      chk("mrst_restart_data", wr_data[0], m_buf[0]);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/buffer_loader.md
Name: buffer_loader

Overview:
- Stream-to-row packer that sits directly upstream of the register-array buffer.
- Accepts IN_WIDTH-bit words on a valid/ready stream and assembles VEC_WIDTH-bit row vectors.
- Writes each completed row to the buffer through its write port (we / addr / data) at incrementing addresses, starting at 0.
- Signals completion once a programmed number of rows has been written.

Parameters:
- IN_WIDTH, 32, width of one input stream word.
- VEC_WIDTH, 384, buffer row width; must be an integer multiple of IN_WIDTH.
- ARR_DEPTH, 16, number of buffer rows.
- ADDR_WIDTH, $clog2(ARR_DEPTH), buffer address width.
- WORDS_PER_VEC (localparam), VEC_WIDTH/IN_WIDTH (default 12), words per row.

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start a load; sampled only in IDLE
- i_num_rows  input  ADDR_WIDTH+1  rows to load; sampled with i_start
- i_abort  input  1  synchronous abort of the load in progress
- i_valid  input  1  input word valid
- i_data  input  IN_WIDTH  input word
- o_ready  output  1  loader accepts a word this cycle
- o_we  output  1  buffer write enable (registered)
- o_addr_wr  output  ADDR_WIDTH  buffer write address (registered)
- o_data_wr  output  VEC_WIDTH  buffer write data (registered)
- o_busy  output  1  high in LOAD or DRAIN
- o_done  output  1  one-cycle completion pulse (registered)

Behaviour:
- Reset (async, i_rst_n low):
  - State IDLE; all outputs 0, including o_data_wr.
  - Word counter, row counter and assembly register cleared.
- States:
  - IDLE -> LOAD on i_start when i_num_rows != 0. i_num_rows is latched; values > ARR_DEPTH clamp to ARR_DEPTH.
  - i_start with i_num_rows == 0 is ignored: stay in IDLE, no o_done.
  - i_start outside IDLE is ignored.
- o_ready = 1 only in LOAD; combinational from state, no dependence on i_valid.
- Accept condition: i_valid && o_ready. On accept, word k (0-based within the row) lands in bits [k*IN_WIDTH +: IN_WIDTH], LSB-first; the word counter increments.
- Row complete (word WORDS_PER_VEC-1 accepted at cycle T). At T+1:
  - o_we = 1, o_addr_wr = row counter, o_data_wr = full row including the final word.
  - Word counter wraps to 0 and the row counter increments.
- o_we is a single-cycle pulse per row. Back-to-back rows are allowed: after a row completes, the next accepted word goes to slot 0 with no bubble.
- o_addr_wr and o_data_wr hold their last values when o_we is low.
- Final row (row counter == latched count-1) completes at T:
  - LOAD -> DRAIN at T+1 (o_ready low, final o_we high).
  - DRAIN -> IDLE at T+2 with o_done = 1 for exactly that cycle, so the consumer can read the buffer immediately.
- o_busy = 1 in LOAD and DRAIN.
- i_abort in LOAD or DRAIN:
  - Next state IDLE; counters cleared; o_we forced 0 next cycle; o_done not asserted.
  - Abort in the same cycle as a final-word accept wins: no write for that row.
  - i_abort in IDLE has no effect.
- Partial rows are never written. A load stalled mid-row stays in LOAD indefinitely.
- Row counter never exceeds ARR_DEPTH-1, so addresses do not wrap within a load. Every new load restarts at address 0.

Decomposition:
- Shared package/header:
  - State encoding: IDLE=2'd0, LOAD=2'd1, DRAIN=2'd2.
  - WORDS_PER_VEC derivation.
  - Divisibility check (VEC_WIDTH % IN_WIDTH == 0) as an elaboration-time error.
- No sub-module is required. The FSM, two counters and the slot-indexed assembly register fit in one module.

Test Plan:
- Reset mid-load: assert i_rst_n low during LOAD after 5 words -> all outputs 0 immediately; no o_we; a later start of 1 row writes address 0 with fresh data.
- Single row, continuous valid: start, i_num_rows=1, words 0x0..0xB -> o_we for one cycle at addr 0, o_data_wr = {32'hB,...,32'h1,32'h0}; o_done one cycle later; o_ready never high again until the next start.
- Full 16 rows, i_valid toggling every other cycle: 192 words with value = index -> 16 o_we pulses at addresses 0..15 in order; row r bits [31:0] = 12r; single o_done after the addr-15 write; a model buffer matches.
- Clamp and zero: i_num_rows=0 -> no state change, no done; i_num_rows=20 -> exactly 16 writes, then done.
- Abort: abort on the cycle the 12th word of row 2 is accepted -> no write to addr 2, no o_done, o_busy low next cycle; a restart loads from addr 0.
- Ignored start: pulse i_start during LOAD with a different count -> the original count is kept; write sequence unchanged.
